uart_load_ctrl: RTL and testbench

//   Sequences the UART word receiver (recv) to bulk-load a memory over the serial link.

---
 rtl/uart_load_ctrl.sv | 139 +++++++++++++
 tb/tb_uart_load_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_load_ctrl.sv
// Bulk-load sequencer for the UART word receiver: header (magic + count), N payload
// words streamed to a BRAM write port, then an XOR checksum trailer.
module uart_load_ctrl #(
  parameter int         WORD_WIDTH     = 24,
  parameter int         ADDR_WIDTH     = 10,
  parameter logic [7:0] MAGIC          = 8'hB1,
  parameter int         TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  start_in,
  input  logic [WORD_WIDTH-1:0] recv_data_in,
  input  logic                  recv_new_in,
  input  logic                  recv_busy_in,
  output logic                  receive_out,
  output logic                  wr_en_out,
  output logic [ADDR_WIDTH-1:0] wr_addr_out,
  output logic [WORD_WIDTH-1:0] wr_data_out,
  output logic [ADDR_WIDTH:0]   count_out,
  output logic                  busy_out,
  output logic                  done_out,
  output logic                  error_out,
  output logic [2:0]            error_code_out
);
  localparam int CW = ADDR_WIDTH + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] MAX_N  = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [2:0] {IDLE, HEADER, LOAD, CHECK, DONE, ERROR} state_t;

  state_t                state_q, state_d;
  logic [2:0]            code_d;
  logic [CW-1:0]         n_q, idx_q;
  logic [WORD_WIDTH-1:0] chk_q;
  logic [TW-1:0]         timer_q;

  logic [CW-1:0] hdr_n;
  logic          magic_ok, count_ok, expired, active_d;

  assign hdr_n    = recv_data_in[ADDR_WIDTH:0];
  assign magic_ok = recv_data_in[WORD_WIDTH-1 -: 8] == MAGIC;
  assign count_ok = (hdr_n != '0) && (hdr_n <= MAX_N);
  assign expired  = timer_q == T_LAST;
  assign active_d = state_d inside {HEADER, LOAD, CHECK};

  // A strobe arriving on the expiry cycle wins over the timeout.
  always_comb begin
    state_d = state_q;
    code_d  = 3'd0;
    case (state_q)
      IDLE, DONE, ERROR: if (start_in) state_d = HEADER;
      HEADER: begin
        if (recv_new_in) begin
          if (!magic_ok)      begin state_d = ERROR; code_d = 3'd1; end
          else if (!count_ok) begin state_d = ERROR; code_d = 3'd2; end
          else                      state_d = LOAD;
        end else if (expired) begin
          state_d = ERROR; code_d = 3'd3;
        end
      end
      LOAD: begin
        if (recv_new_in) begin
          if (idx_q == n_q - CW'(1)) state_d = CHECK;
        end else if (expired) begin
          state_d = ERROR; code_d = 3'd3;
        end
      end
      CHECK: begin
        if (recv_new_in) begin
          if (recv_data_in == chk_q) state_d = DONE;
          else begin state_d = ERROR; code_d = 3'd4; end
        end else if (expired) begin
          state_d = ERROR; code_d = 3'd3;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q        <= IDLE;
      n_q            <= '0;
      idx_q          <= '0;
      chk_q          <= '0;
      timer_q        <= '0;
      receive_out    <= 1'b0;
      busy_out       <= 1'b0;
      wr_en_out      <= 1'b0;
      wr_addr_out    <= '0;
      wr_data_out    <= '0;
      count_out      <= '0;
      done_out       <= 1'b0;
      error_out      <= 1'b0;
      error_code_out <= 3'd0;
    end else begin
      state_q     <= state_d;
      receive_out <= active_d;
      busy_out    <= active_d;
      wr_en_out   <= 1'b0;

      if (state_d != state_q || recv_new_in)
        timer_q <= '0;
      else if (state_q inside {HEADER, LOAD, CHECK} && !recv_busy_in)
        timer_q <= timer_q + TW'(1);

      case (state_q)
        IDLE, DONE, ERROR: if (start_in) begin
          done_out       <= 1'b0;
          error_out      <= 1'b0;
          error_code_out <= 3'd0;
          count_out      <= '0;
          chk_q          <= '0;
        end
        HEADER: if (recv_new_in) begin
          n_q   <= hdr_n;
          idx_q <= '0;
          chk_q <= '0;
        end
        LOAD: if (recv_new_in) begin
          wr_en_out   <= 1'b1;
          wr_addr_out <= idx_q[ADDR_WIDTH-1:0];
          wr_data_out <= recv_data_in;
          chk_q       <= chk_q ^ recv_data_in;
          idx_q       <= idx_q + CW'(1);
          count_out   <= idx_q + CW'(1);
        end
        default: ;
      endcase

      if (state_d == DONE && state_q != DONE) done_out <= 1'b1;
      if (state_d == ERROR && state_q != ERROR) begin
        error_out      <= 1'b1;
        error_code_out <= code_d;
      end
    end
  end
endmodule

// File: tb/tb_uart_load_ctrl.sv
// Randomized scoreboard bench for uart_load_ctrl: a frame-level model predicts the
// BRAM writes and final status; a monitor checks every write strobe against the queue.
module tb_uart_load_ctrl;
  localparam int WW = 24, AW = 10, TO = 50;

  logic          clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [WW-1:0] rdata = '0;
  logic          rnew = 1'b0, rbusy = 1'b0;
  logic          receive, wr_en, busy, done, error;
  logic [AW-1:0] wr_addr;
  logic [WW-1:0] wr_data;
  logic [AW:0]   count;
  logic [2:0]    code;

  int total = 0, bad = 0;
  logic [AW+WW-1:0] exp_q[$];
  logic [WW-1:0]    pay_q[$];

  uart_load_ctrl #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW), .MAGIC(8'hB1), .TIMEOUT_CYCLES(TO)) dut (
    .clk_in(clk), .rst_in(rst), .start_in(start),
    .recv_data_in(rdata), .recv_new_in(rnew), .recv_busy_in(rbusy),
    .receive_out(receive), .wr_en_out(wr_en), .wr_addr_out(wr_addr), .wr_data_out(wr_data),
    .count_out(count), .busy_out(busy), .done_out(done), .error_out(error),
    .error_code_out(code));

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endfunction

  // Monitor: every write strobe must match the oldest predicted write.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_write", {wr_addr, wr_data}, '1);
      else check("write", {wr_addr, wr_data}, exp_q.pop_front());
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_word(input logic [WW-1:0] w);
    rdata = w; rnew = 1'b1;
    @(posedge clk); #1;
    rnew = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    if (k == 100) check("wait_idle_timeout", 1, 0);
  endtask

  task automatic check_status(input string tag, input int ecode, input int cnt);
    check({tag, "_done"}, done, ecode == 0);
    check({tag, "_error"}, error, ecode != 0);
    check({tag, "_code"}, code, ecode);
    check({tag, "_count"}, count, cnt);
    check({tag, "_receive"}, receive, 0);
    check({tag, "_pending_writes"}, exp_q.size(), 0);
  endtask

  // Frame-level model: decide outcome from header and checksum rules, queue the writes,
  // then drive the frame with random gaps of up to gapmax idle cycles.
  task automatic load_frame(input string tag, input logic [WW-1:0] hdr,
                            input bit bad_trailer, input int gapmax);
    int n, ecode, cnt;
    logic [WW-1:0] x;
    n = int'(hdr[AW:0]); x = '0; cnt = 0;
    if (hdr[WW-1 -: 8] != 8'hB1) ecode = 1;
    else if (n == 0 || n > (1 << AW)) ecode = 2;
    else begin
      for (int i = 0; i < n; i++) begin
        exp_q.push_back({AW'(i), pay_q[i]});
        x ^= pay_q[i];
      end
      ecode = bad_trailer ? 4 : 0;
      cnt = n;
    end
    pulse_start();
    send_word(hdr);
    if (ecode == 0 || ecode == 4) begin
      for (int i = 0; i < n; i++) begin
        idle($urandom_range(gapmax, 0));
        send_word(pay_q[i]);
      end
      idle($urandom_range(gapmax, 0));
      send_word(bad_trailer ? (x ^ WW'($urandom_range(255, 1))) : x);
    end
    wait_idle();
    check_status(tag, ecode, cnt);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_outputs", {receive, wr_en, wr_addr, wr_data, count, busy, done, error, code}, '0);

    // Directed frame with a start pulse mid-load that must be ignored.
    exp_q.push_back({10'd0, 24'h11}); exp_q.push_back({10'd1, 24'h22}); exp_q.push_back({10'd2, 24'h44});
    pulse_start();
    send_word(24'hB10003);
    @(negedge clk);
    check("hdr_receive", receive, 1);
    check("hdr_busy", busy, 1);
    pulse_start();
    send_word(24'h11); send_word(24'h22); idle(2); send_word(24'h44); idle(1);
    send_word(24'h77);
    wait_idle();
    check_status("t1", 0, 3);
    check("hold_addr", wr_addr, 2);
    check("hold_data", wr_data, 24'h44);

    // Header rejection cases.
    pay_q.delete();
    load_frame("bad_magic", 24'hA00003, 0, 0);
    load_frame("count_zero", 24'hB10000, 0, 0);
    load_frame("count_1025", 24'hB10401, 0, 0);

    // Largest legal payload, back-to-back strobes.
    pay_q.delete();
    for (int i = 0; i < 1024; i++) pay_q.push_back(WW'($urandom));
    load_frame("max_count", 24'hB10400, 0, 0);

    // Directed checksum failure.
    pay_q.delete();
    pay_q.push_back(24'h11); pay_q.push_back(24'h22); pay_q.push_back(24'h44);
    load_frame("bad_chk", 24'hB10003, 1, 0);

    // Timeout after 50 idle cycles in LOAD.
    pulse_start();
    send_word(24'hB10002);
    repeat (TO - 1) @(posedge clk);
    @(negedge clk);
    check("pre_timeout_error", error, 0);
    @(posedge clk); @(negedge clk);
    check_status("timeout", 3, 0);
    check("timeout_busy", busy, 0);

    // Receiver busy holds the timer.
    rbusy = 1'b1;
    exp_q.push_back({10'd0, 24'h5}); exp_q.push_back({10'd1, 24'h6});
    pulse_start();
    send_word(24'hB10002);
    idle(4 * TO);
    check("stall_no_timeout", error, 0);
    check("stall_busy", busy, 1);
    send_word(24'h5); send_word(24'h6); send_word(24'h3);
    wait_idle();
    check_status("stall", 0, 2);
    rbusy = 1'b0;

    // Strobe on the expiry cycle is taken instead of timing out.
    exp_q.push_back({10'd0, 24'h5}); exp_q.push_back({10'd1, 24'h6});
    pulse_start();
    send_word(24'hB10002);
    repeat (TO - 1) @(posedge clk);
    #1 send_word(24'h5);
    check("expiry_race_error", error, 0);
    send_word(24'h6); send_word(24'h3);
    wait_idle();
    check_status("expiry_race", 0, 2);

    // Random frames.
    for (int t = 0; t < 12; t++) begin
      int kind, n;
      logic [10:0] nf;
      logic [7:0] mg;
      kind = $urandom_range(3, 0);
      n = $urandom_range(6, 1);
      mg = 8'hB1; nf = 11'(n);
      if (kind == 1) mg = 8'hB1 ^ 8'($urandom_range(255, 1));
      if (kind == 2) nf = $urandom_range(1, 0) ? 11'd0 : 11'($urandom_range(2047, 1025));
      pay_q.delete();
      for (int i = 0; i < n; i++) pay_q.push_back(WW'($urandom));
      load_frame($sformatf("rand%0d", t), {mg, 5'($urandom), nf}, kind == 3, 3);
    end

    // Reset mid-load, then stray strobes without start.
    exp_q.push_back({10'd0, 24'hABC});
    pulse_start();
    send_word(24'hB10003);
    send_word(24'hABC);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midload_reset", {receive, wr_en, wr_addr, wr_data, count, busy, done, error, code}, '0);
    send_word(24'h1); send_word(24'h2); idle(3);
    @(negedge clk);
    check("post_reset_idle", {receive, busy, done, error, count}, '0);

    // Clean rerun of the directed frame with consecutive strobes.
    pay_q.delete();
    pay_q.push_back(24'h11); pay_q.push_back(24'h22); pay_q.push_back(24'h44);
    load_frame("t1_rerun", 24'hB10003, 0, 0);

    idle(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
